phtime_tcnt_gen: RTL and testbench

- Generates the registered `freq` / `tcnt` operand pair that feeds the phase-time multiplier stage (`phasetime = freq*tcnt`, truncated to 27 bits, one register).
- Owns the time counter, accepts frequency updates over a valid/ready handshake, and holds each update until the counter restarts, so the product always restarts from zero on the new frequency.
- Sits between the command/parameter path and the phase-time multiplier in the per-channel DDS phase chain.

---
 rtl/phtime_tcnt_gen.sv | 135 +++++++++++++
 tb/tb_phtime_tcnt_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/phtime_tcnt_gen.sv
// phtime_tcnt_gen: registered freq/tcnt operand pair for the phase-time multiplier.
// Owns the time counter, accepts frequency words over a valid/ready handshake
// and holds a word received while running until the counter restarts, so the
// product freq*tcnt always restarts from zero on the new frequency.
// Optional build macro: PHTIME_TCNT_GEN_ERRCNT_EN adds a 16-bit saturating
// counter (errcnt) of cycles where freq_valid is high while freq_ready is low.
module phtime_tcnt_gen #(
  parameter int TCNTWIDTH = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] freq_in,
  input  logic        freq_valid,
  output logic        freq_ready,
  input  logic        sync,
  output logic [26:0] freq,
  output logic [26:0] tcnt,
  output logic        tcntlast,
  output logic        valid
`ifdef PHTIME_TCNT_GEN_ERRCNT_EN
  ,
  output logic [15:0] errcnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [TCNTWIDTH-1:0] CNT_MAX = '1;
  localparam logic [TCNTWIDTH-1:0] CNT_ONE = TCNTWIDTH'(1);

  state_t               r_state;
  logic [TCNTWIDTH-1:0] r_cnt;
  logic [26:0]          r_freq;
  logic [26:0]          r_pend;
  logic                 r_tcntlast;
  logic                 r_valid;
  logic                 r_ready;

  logic                 w_hs;
  logic                 w_apply;
  logic [TCNTWIDTH-1:0] w_cnt_inc;
  logic [TCNTWIDTH-1:0] w_cnt_nxt;

  assign w_hs      = freq_valid & r_ready;
  assign w_cnt_inc = r_cnt + CNT_ONE;

  // Next counter value and the pending-apply decision (tcntlast is the
  // registered flag for the value currently shown, so it selects the wrap edge).
  always_comb begin
    w_apply   = (r_state == PEND) && (r_tcntlast || sync);
    w_cnt_nxt = '0;
    case (r_state)
      IDLE:    w_cnt_nxt = '0;
      RUN:     w_cnt_nxt = sync ? '0 : w_cnt_inc;
      PEND:    w_cnt_nxt = w_apply ? '0 : w_cnt_inc;
      default: w_cnt_nxt = '0;
    endcase
  end

  // Control FSM with registered operand pair, ready and last flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_freq     <= '0;
      r_pend     <= '0;
      r_tcntlast <= 1'b0;
      r_valid    <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_tcntlast <= (w_cnt_nxt == CNT_MAX);
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_freq  <= freq_in;
            r_valid <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_hs) begin
            r_pend  <= freq_in;
            r_ready <= 1'b0;
            r_state <= PEND;
          end
        end
        PEND: begin
          if (w_apply) begin
            r_freq  <= r_pend;
            r_ready <= 1'b1;
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  generate
    if (TCNTWIDTH < 27) begin : g_zext
      assign tcnt = {{(27 - TCNTWIDTH){1'b0}}, r_cnt};
    end else begin : g_full
      assign tcnt = r_cnt;
    end
  endgenerate

  assign freq       = r_freq;
  assign tcntlast   = r_tcntlast;
  assign valid      = r_valid;
  assign freq_ready = r_ready;

`ifdef PHTIME_TCNT_GEN_ERRCNT_EN
  logic [15:0] r_errcnt;

  // Saturating count of offers made while the block cannot accept them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_errcnt <= '0;
    end else if (freq_valid && !r_ready && (r_errcnt != 16'hFFFF)) begin
      r_errcnt <= r_errcnt + 16'd1;
    end
  end

  assign errcnt = r_errcnt;
`endif

endmodule

// File: tb/tb_phtime_tcnt_gen.sv
// Testbench for phtime_tcnt_gen (TCNTWIDTH=4): a driver issues per-cycle
// stimulus and pushes the reference model's expected outputs into a queue; a
// monitor pops one entry after every clock edge and compares.
module tb_phtime_tcnt_gen;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [26:0] freq_in = '0;
  logic        freq_valid = 1'b0;
  logic        freq_ready;
  logic        sync = 1'b0;
  logic [26:0] freq;
  logic [26:0] tcnt;
  logic        tcntlast;
  logic        valid;
`ifdef PHTIME_TCNT_GEN_ERRCNT_EN
  logic [15:0] errcnt;
`endif

  phtime_tcnt_gen #(.TCNTWIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .freq_in    (freq_in),
    .freq_valid (freq_valid),
    .freq_ready (freq_ready),
    .sync       (sync),
    .freq       (freq),
    .tcnt       (tcnt),
    .tcntlast   (tcntlast),
    .valid      (valid)
`ifdef PHTIME_TCNT_GEN_ERRCNT_EN
    ,
    .errcnt     (errcnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned freq;
    int unsigned tcnt;
    bit          last;
    bit          valid;
    bit          ready;
    int unsigned errcnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: behavioural view of the operand pair.
  bit          m_started;   // a first frequency has been taken
  bit          m_has_pend;  // an update is waiting for the counter restart
  int unsigned m_pend;
  int unsigned m_freq;
  int          m_t;
  int unsigned m_err;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_started  = 0;
    m_has_pend = 0;
    m_pend     = 0;
    m_freq     = 0;
    m_t        = 0;
    m_err      = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.freq   = m_freq;
    e.tcnt   = m_t;
    e.last   = m_started && (m_t == M - 1);
    e.valid  = m_started;
    e.ready  = !m_has_pend;
    e.errcnt = m_err;
    return e;
  endfunction

  // One clock: drive inputs at the falling edge, advance the model for the
  // following rising edge and queue the expected post-edge outputs.
  task automatic step(input bit fv, input int unsigned fin, input bit sy);
    bit hs;
    @(negedge clk);
    freq_valid = fv;
    freq_in    = fin[26:0];
    sync       = sy;
    hs = fv && !m_has_pend;
    if (fv && m_has_pend && m_err < 65535) m_err++;
    if (!m_started) begin
      if (hs) begin
        m_started = 1;
        m_freq    = fin & 32'h07FF_FFFF;
        m_t       = 0;
      end
    end else if (!m_has_pend) begin
      m_t = sy ? 0 : (m_t + 1) % M;
      if (hs) begin
        m_has_pend = 1;
        m_pend     = fin & 32'h07FF_FFFF;
      end
    end else begin
      if (sy || m_t == M - 1) begin
        m_freq     = m_pend;
        m_has_pend = 0;
        m_t        = 0;
      end else begin
        m_t = (m_t + 1) % M;
      end
    end
    q.push_back(model_out());
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_freq"},  freq,       0);
    chk({tag, "_tcnt"},  tcnt,       0);
    chk({tag, "_last"},  tcntlast,   0);
    chk({tag, "_valid"}, valid,      0);
    chk({tag, "_ready"}, freq_ready, 1);
`ifdef PHTIME_TCNT_GEN_ERRCNT_EN
    chk({tag, "_errcnt"}, errcnt, 0);
`endif
  endtask

  // Idle-step until the model's counter reaches the target; bounded.
  task automatic wait_t(input int target, input string tag);
    int n = 0;
    while (m_t != target && n < 4 * M) begin
      step(0, 0, 0);
      n++;
    end
    if (m_t != target) chk({tag, "_wait_timeout"}, 0, 1);
  endtask

  // Monitor: one expected entry per rising edge that had stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("freq",  freq,       e.freq);
        chk("tcnt",  tcnt,       e.tcnt);
        chk("last",  tcntlast,   e.last);
        chk("valid", valid,      e.valid);
        chk("ready", freq_ready, e.ready);
`ifdef PHTIME_TCNT_GEN_ERRCNT_EN
        chk("errcnt", errcnt, e.errcnt);
`endif
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // IDLE ignores sync; first handshake then free count with wrap
    step(0, 0, 1);
    step(1, 27'h0123456, 0);
    repeat (20) step(0, 0, 0);

    // RUN handshake at tcnt=5, applied at the wrap
    wait_t(5, "run5");
    step(1, 27'h0000100, 0);
    repeat (12) step(0, 0, 0);

    // PEND applied early by sync at tcnt=7
    step(1, 27'h0000ABC, 0);
    wait_t(7, "pend7");
    step(0, 0, 1);
    step(0, 0, 0);

    // sync coincident with tcntlast: single apply
    step(1, 27'h7FFFFFF, 0);
    wait_t(15, "pend15");
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);

    // RUN handshake together with sync: restart, update only pending
    step(1, 27'h0055AA0, 1);
    repeat (M + 2) step(0, 0, 0);

    // Offers while PEND (error counting), then async reset mid-PEND
    step(1, 27'h0001111, 0);
    wait_t(2, "pendr");
    repeat (10) step(1, 27'h0002222, 0);
    @(negedge clk);
    freq_valid = 1'b0;
    sync       = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1, 27'h0003333, 0);
    repeat (M + 4) step(0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 3), $urandom, ($urandom_range(0, 19) == 0));
    end

`ifdef PHTIME_TCNT_GEN_ERRCNT_EN
    // Continuous offers long enough to saturate the error counter
    for (int i = 0; i < 70000; i++) step(1, $urandom, 0);
    repeat (3) step(1, 0, 0);
`endif

    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
